// File: rtl/gcd_operand_sequencer.sv
// Operand-pair FIFO feeding the GCD core's serial load protocol (start, A, B), result on valid/ready.
// Dispatch LOAD_A one edge after a pair lands in IDLE; zero operands bypass the core; dispatch stalls while the result is unconsumed.

module gcd_seq_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop_vld,
  output logic [DW-1:0] head_dat,
  output logic          empty,
  output logic          full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop_vld && !empty;
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign push_ok  = push_vld && (!full || pop_ok);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

module gcd_operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             busy
);
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam int             WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [WDW-1:0]   wd;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  pair_t in_pair;
  pair_t head;
  logic  fifo_empty;
  logic  fifo_full;
  logic  push_vld;
  logic  out_free;
  logic  head_zero;
  logic  take;
  logic  done_hit;
  logic  timeout_hit;

  assign in_pair   = '{a: in_a, b: in_b};
  assign in_ready  = rst_n && !fifo_full;
  assign push_vld  = in_valid && in_ready;
  assign out_free  = !out_valid || out_ready;
  assign head_zero = (head.a == '0) || (head.b == '0);
  assign take      = (state == S_IDLE) && !fifo_empty && out_free;

  assign done_hit    = (state == S_WAIT) && gcd_done;
  assign timeout_hit = (state == S_WAIT) && !gcd_done && (wd == WD_LAST);

  gcd_seq_fifo #(
    .DW    ($bits(pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (in_pair),
    .pop_vld  (take),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wd    <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take && !head_zero) begin
            op_a  <= head.a;
            op_b  <= head.b;
            state <= S_LOAD_A;
          end
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_LOAD_B: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (gcd_done || (wd == WD_LAST)) state <= S_DRAIN;
          else                             wd    <= wd + 1'b1;
        end
        // One cycle with start low lets the core fall back to its idle state.
        S_DRAIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_err   <= 1'b0;
    end else if (take && head_zero) begin
      out_valid <= 1'b1;
      out_gcd   <= head.a | head.b;
      out_err   <= 1'b0;
    end else if (done_hit) begin
      out_valid <= 1'b1;
      out_gcd   <= gcd_result;
      out_err   <= 1'b0;
    end else if (timeout_hit) begin
      out_valid <= 1'b1;
      out_gcd   <= '0;
      out_err   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign gcd_start = (state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_WAIT);
  assign busy      = (state != S_IDLE) || !fifo_empty;

  always_comb begin
    gcd_data = '0;
    case (state)
      S_LOAD_A:        gcd_data = op_a;
      S_LOAD_B, S_WAIT: gcd_data = op_b;
      default:         gcd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Bench for gcd_operand_sequencer with a behavioural GCD core and a result scoreboard.
module tb_gcd_operand_sequencer;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TO = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done = 1'b0;
  logic [W-1:0] gcd_result = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] g;
    logic         e;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   start_cnt = 0;
  bit   core_en   = 1'b1;

  gcd_operand_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .gcd_start  (gcd_start),
    .gcd_data   (gcd_data),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x_in, input logic [W-1:0] y_in);
    logic [W-1:0] x, y, t;
    x = x_in;
    y = y_in;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: latch A then B from consecutive start cycles, raise done a few cycles later.
  initial begin : core_model
    int phase;
    int lat;
    logic [W-1:0] ca, cb;
    phase = 0; lat = 0; ca = '0; cb = '0;
    forever begin
      @(negedge clk);
      if (gcd_start) start_cnt++;
      if (!rst_n || !core_en) begin
        phase = 0;
        gcd_done = 1'b0;
      end else begin
        case (phase)
          0: if (gcd_start) begin ca = gcd_data; phase = 1; end
          1: if (gcd_start) begin cb = gcd_data; phase = 2; lat = 3; end else phase = 0;
          2: begin
            if (!gcd_start) phase = 0;
            else if (lat == 0) begin
              gcd_done = 1'b1;
              gcd_result = gcd_ref(ca, cb);
              phase = 3;
            end else lat--;
          end
          default: if (!gcd_start) begin gcd_done = 1'b0; phase = 0; end
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eg, input logic ee, output bit ok);
    exp_q.push_back(exp_t'{g: eg, e: ee});
    in_a = a; in_b = b; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output logic [W-1:0] g, output logic e, output bit ok);
    ok = 1'b0; g = '0; e = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin g = out_gcd; e = out_err; ok = 1'b1; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    check_cnt++; if (gcd_start !== 1'b0) $display("FAIL rst_start: got %b expected 0", gcd_start); else pass_cnt++;
    check_cnt++; if (gcd_data !== '0) $display("FAIL rst_data: got %0d expected 0", gcd_data); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    check_cnt++; if (out_gcd !== '0) $display("FAIL rst_out_gcd: got %0d expected 0", out_gcd); else pass_cnt++;
    check_cnt++; if (out_err !== 1'b0) $display("FAIL rst_out_err: got %b expected 0", out_err); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    bit ok, seen;
    exp_t ex;
    out_ready = 1'b1;
    push_pair(16'd90, 16'd81, 16'd9, 1'b0, ok);
    check_cnt++; if (!ok) $display("FAIL basic_accept: got 0 expected 1"); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (gcd_start !== 1'b0) $display("FAIL basic_e0_start: got %b expected 0", gcd_start); else pass_cnt++;
    @(posedge clk); #1; @(negedge clk);
    check_cnt++; if (gcd_start !== 1'b1 || gcd_data !== 16'd90) $display("FAIL basic_load_a: got start=%b data=%0d expected 1/90", gcd_start, gcd_data); else pass_cnt++;
    @(posedge clk); #1; @(negedge clk);
    check_cnt++; if (gcd_start !== 1'b1 || gcd_data !== 16'd81) $display("FAIL basic_load_b: got start=%b data=%0d expected 1/81", gcd_start, gcd_data); else pass_cnt++;
    @(posedge clk); #1; @(negedge clk);
    check_cnt++; if (gcd_start !== 1'b1 || gcd_data !== 16'd81) $display("FAIL basic_wait: got start=%b data=%0d expected 1/81", gcd_start, gcd_data); else pass_cnt++;
    @(posedge clk); #1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check_cnt++; if (gcd_start !== 1'b0 || gcd_data !== '0) $display("FAIL basic_drain: got start=%b data=%0d expected 0/0", gcd_start, gcd_data); else pass_cnt++;
        ex = exp_q.pop_front();
        check_cnt++; if (out_gcd !== ex.g || out_err !== ex.e) $display("FAIL basic_result: got %0d/%b expected %0d/%b", out_gcd, out_err, ex.g, ex.e); else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    check_cnt++; if (!seen) $display("FAIL basic_out_valid: got no result expected one"); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (gcd_start !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle: got start=%b busy=%b expected 0/0", gcd_start, busy); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_bypass();
    bit ok;
    exp_t ex;
    int s0;
    logic [W-1:0] ta [2] = '{16'd0, 16'd0};
    logic [W-1:0] tb_ [2] = '{16'd48, 16'd0};
    logic [W-1:0] tg [2] = '{16'd48, 16'd0};
    out_ready = 1'b1;
    s0 = start_cnt;
    for (int k = 0; k < 2; k++) begin
      push_pair(ta[k], tb_[k], tg[k], 1'b0, ok);
      check_cnt++; if (!ok) $display("FAIL bypass_accept_%0d: got 0 expected 1", k); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (out_valid !== 1'b0) $display("FAIL bypass_early_%0d: got %b expected 0", k, out_valid); else pass_cnt++;
      @(posedge clk); #1; @(negedge clk);
      ex = exp_q.pop_front();
      check_cnt++; if (out_valid !== 1'b1 || out_gcd !== ex.g || out_err !== ex.e) $display("FAIL bypass_result_%0d: got v=%b %0d/%b expected 1 %0d/%b", k, out_valid, out_gcd, out_err, ex.g, ex.e); else pass_cnt++;
      @(posedge clk); #1;
    end
    check_cnt++; if (start_cnt != s0) $display("FAIL bypass_no_start: got %0d start cycles expected 0", start_cnt - s0); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ta [6] = '{16'd12, 16'd35, 16'd21, 16'd40, 16'd27, 16'd22};
    logic [W-1:0] tb_ [6] = '{16'd18, 16'd14, 16'd49, 16'd64, 16'd45, 16'd33};
    logic [W-1:0] tg [6] = '{16'd6, 16'd7, 16'd7, 16'd8, 16'd9, 16'd11};
    bit ok, held;
    logic r0, r1;
    out_ready = 1'b0;
    for (int k = 0; k < D + 1; k++) begin
      push_pair(ta[k], tb_[k], tg[k], 1'b0, ok);
      check_cnt++; if (!ok) $display("FAIL bp_accept_%0d: got 0 expected 1", k); else pass_cnt++;
    end
    exp_q.push_back(exp_t'{g: tg[5], e: 1'b0});
    in_a = ta[5]; in_b = tb_[5]; in_valid = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) held = 1'b0;
      @(posedge clk); #1;
    end
    check_cnt++; if (!held) $display("FAIL bp_full_hold: got in_ready=1 expected 0"); else pass_cnt++;
    out_ready = 1'b1;
    r0 = 1'bx; r1 = 1'bx;
    fork
      begin
        @(negedge clk); r0 = in_ready;
        @(posedge clk); #1;
        @(negedge clk); r1 = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        logic [W-1:0] g;
        logic e;
        bit got;
        exp_t ex;
        for (int k = 0; k < 6; k++) begin
          wait_out(60, g, e, got);
          check_cnt++;
          if (!got || exp_q.size() == 0) $display("FAIL bp_result_%0d: got none expected %0d", k, tg[k]);
          else begin
            ex = exp_q.pop_front();
            if (g !== ex.g || e !== ex.e) $display("FAIL bp_result_%0d: got %0d/%b expected %0d/%b", k, g, e, ex.g, ex.e);
            else pass_cnt++;
          end
        end
      end
    join
    check_cnt++; if (r0 !== 1'b0) $display("FAIL bp_ready_before_pop: got %b expected 0", r0); else pass_cnt++;
    check_cnt++; if (r1 !== 1'b1) $display("FAIL bp_ready_after_pop: got %b expected 1", r1); else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit ok, ok2, seen;
    int s0;
    exp_t ex;
    logic [W-1:0] g;
    logic e;
    core_en = 1'b0;
    out_ready = 1'b1;
    s0 = start_cnt;
    push_pair(16'd10, 16'd4, 16'd0, 1'b1, ok);
    push_pair(16'd9, 16'd6, 16'd3, 1'b0, ok2);
    check_cnt++; if (!ok || !ok2) $display("FAIL to_accept: got %b%b expected 11", ok, ok2); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < TO + 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check_cnt++; if (start_cnt - s0 != TO + 2) $display("FAIL to_start_cycles: got %0d expected %0d", start_cnt - s0, TO + 2); else pass_cnt++;
        ex = exp_q.pop_front();
        check_cnt++; if (out_gcd !== ex.g || out_err !== ex.e) $display("FAIL to_result: got %0d/%b expected %0d/%b", out_gcd, out_err, ex.g, ex.e); else pass_cnt++;
        core_en = 1'b1;
      end
      @(posedge clk); #1;
    end
    check_cnt++; if (!seen) $display("FAIL to_out_valid: got no result expected one"); else pass_cnt++;
    core_en = 1'b1;
    wait_out(60, g, e, ok);
    check_cnt++;
    if (!ok || exp_q.size() == 0) $display("FAIL to_next_result: got none expected 3");
    else begin
      ex = exp_q.pop_front();
      if (g !== ex.g || e !== ex.e) $display("FAIL to_next_result: got %0d/%b expected %0d/%b", g, e, ex.g, ex.e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2, quiet;
    exp_t ex;
    logic [W-1:0] g;
    logic e;
    out_ready = 1'b1;
    push_pair(16'd100, 16'd75, 16'd25, 1'b0, ok);
    push_pair(16'd8, 16'd12, 16'd4, 1'b0, ok2);
    @(posedge clk); @(posedge clk); #2;
    check_cnt++; if (gcd_start !== 1'b1 || gcd_data !== 16'd75) $display("FAIL rm_in_wait: got start=%b data=%0d expected 1/75", gcd_start, gcd_data); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++; if (gcd_start !== 1'b0 || gcd_data !== '0) $display("FAIL rm_core_if: got start=%b data=%0d expected 0/0", gcd_start, gcd_data); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b0 || out_gcd !== '0 || out_err !== 1'b0) $display("FAIL rm_output: got v=%b %0d/%b expected 0 0/0", out_valid, out_gcd, out_err); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL rm_busy_ready: got busy=%b ready=%b expected 0/0", busy, in_ready); else pass_cnt++;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || out_valid || gcd_start) quiet = 1'b0;
      @(posedge clk); #1;
    end
    check_cnt++; if (!quiet) $display("FAIL rm_fifo_empty: got activity after reset expected none"); else pass_cnt++;
    push_pair(16'd100, 16'd75, 16'd25, 1'b0, ok);
    wait_out(60, g, e, ok);
    check_cnt++;
    if (!ok || exp_q.size() == 0) $display("FAIL rm_result: got none expected 25");
    else begin
      ex = exp_q.pop_front();
      if (g !== ex.g || e !== ex.e) $display("FAIL rm_result: got %0d/%b expected %0d/%b", g, e, ex.g, ex.e);
      else pass_cnt++;
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_basic();
    test_zero_bypass();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
